hat_round_sequencer: RTL and testbench

Controller that sequences the game's 14-bit hat counter through a fixed number of rounds. Drives the counter's clear (`cnt_go`) and increment (`cnt_en`) controls, divides the system clock into count ticks, and detects end-of-round by comparing the counter value against `MAXCOUNT`. Supports player pause/resume and reports per-round and end-of-game events to the game FSM.

---
 rtl/hat_round_sequencer_if.sv | 23 ++
 rtl/hat_round_sequencer.sv | 103 ++++++++++
 tb/tb_hat_round_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hat_round_sequencer_if.sv
// Control/status bundle between the hat round sequencer and the game side.
// master = game FSM and counter side, slave = sequencer.
interface hat_round_sequencer_if;
  logic        start;
  logic        pause;
  logic [13:0] count_in;
  logic        cnt_go;
  logic        cnt_en;
  logic [2:0]  round;
  logic        busy;
  logic        round_done;
  logic        all_done;

  modport master (
    output start, pause, count_in,
    input  cnt_go, cnt_en, round, busy, round_done, all_done
  );

  modport slave (
    input  start, pause, count_in,
    output cnt_go, cnt_en, round, busy, round_done, all_done
  );
endinterface

// File: rtl/hat_round_sequencer.sv
// Sequences the 14-bit hat counter through ROUNDS rounds with a TICK_DIV prescaler.
// Define HAT_PAUSE_EN to enable player pause/resume; otherwise pause is ignored.
module hat_round_sequencer #(
  parameter logic [13:0] MAXCOUNT = 14'd12348,
  parameter int          TICK_DIV = 50000,
  parameter int          ROUNDS   = 4
) (
  input logic                  clk,
  input logic                  reset,
  hat_round_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, PAUSED, ROUND_END, DONE} state_t;

  localparam logic [15:0] PRE_LAST   = 16'(TICK_DIV - 1);
  localparam logic [2:0]  ROUND_LAST = 3'(ROUNDS - 1);

  state_t      state, state_next;
  logic [15:0] pre;
  logic [2:0]  round_q;
  logic        end_hit;
  logic        pause_req;
  logic        cnt_go, cnt_en, busy, round_done, all_done;

  assign end_hit = (bus.count_in >= MAXCOUNT);

`ifdef HAT_PAUSE_EN
  assign pause_req = bus.pause;
`else
  logic pause_unused;
  assign pause_unused = bus.pause;
  assign pause_req    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    cnt_go     = 1'b0;
    cnt_en     = 1'b0;
    busy       = 1'b0;
    round_done = 1'b0;
    all_done   = 1'b0;
    unique case (state)
      IDLE: if (bus.start) state_next = LOAD;
      LOAD: begin
        cnt_go     = 1'b1;
        busy       = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // The enable is withheld on the end-of-round cycle so the counter stops at MAXCOUNT.
        cnt_en = (pre == PRE_LAST) && !end_hit;
        if (end_hit)        state_next = ROUND_END;
        else if (pause_req) state_next = PAUSED;
      end
      PAUSED: begin
        busy = 1'b1;
        if (pause_req) state_next = RUN;
      end
      ROUND_END: begin
        busy       = 1'b1;
        round_done = 1'b1;
        state_next = (round_q == ROUND_LAST) ? DONE : LOAD;
      end
      DONE: begin
        all_done = 1'b1;
        if (bus.start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Prescaler free-runs in RUN only; PAUSED holds it so resume continues mid-tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre     <= '0;
      round_q <= '0;
    end else begin
      unique case (state)
        LOAD:      pre <= '0;
        RUN:       pre <= (pre == PRE_LAST) ? '0 : pre + 16'd1;
        ROUND_END: if (round_q != ROUND_LAST) round_q <= round_q + 3'd1;
        DONE:      if (bus.start) round_q <= '0;
        default:   ;
      endcase
    end
  end

  assign bus.cnt_go     = cnt_go;
  assign bus.cnt_en     = cnt_en;
  assign bus.round      = round_q;
  assign bus.busy       = busy;
  assign bus.round_done = round_done;
  assign bus.all_done   = all_done;

endmodule

// File: tb/tb_hat_round_sequencer.sv
// Bench for hat_round_sequencer: directed vector table, hand sequences for pause/reset/overrun,
// then random stimulus checked against a phase/tick-count reference model.
module tb_hat_round_sequencer;

  localparam logic [13:0] MC = 14'd5;
  localparam int          TD = 3;
  localparam int          RN = 2;
`ifdef HAT_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] cnt = '0;

  hat_round_sequencer_if bus();
  assign bus.count_in = cnt;

  hat_round_sequencer #(.MAXCOUNT(MC), .TICK_DIV(TD), .ROUNDS(RN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: game phase, active RUN cycles since LOAD, round index.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_PAUSED, M_END, M_DONE} mphase_t;
  mphase_t m_ph     = M_IDLE;
  int      m_ticks  = 0;
  int      m_round  = 0;

  int n_vec      = 0;
  int n_bad      = 0;
  int rdone_seen = 0;

  typedef struct {
    bit       rst, st, ps;
    bit       go, en;
    bit [2:0] rnd;
    bit       busy, rdone, adone;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic bit exp_en();
    return (m_ph == M_RUN) && ((m_ticks % TD) == TD - 1) && (cnt < MC);
  endfunction

  task automatic check_model();
    check("model cnt_go",     32'(bus.cnt_go),     32'(m_ph == M_LOAD));
    check("model cnt_en",     32'(bus.cnt_en),     32'(exp_en()));
    check("model round",      32'(bus.round),      m_round);
    check("model busy",       32'(bus.busy),       32'(m_ph inside {M_LOAD, M_RUN, M_PAUSED, M_END}));
    check("model round_done", 32'(bus.round_done), 32'(m_ph == M_END));
    check("model all_done",   32'(bus.all_done),   32'(m_ph == M_DONE));
  endtask

  // Drive one cycle's inputs at the falling edge, advance one rising edge, then compare.
  task automatic step(input int r, input int s, input int p);
    logic [13:0] c_next;
    mphase_t     nph;
    int          nt, nr;
    reset     = (r != 0);
    bus.start = (s != 0);
    bus.pause = (p != 0);
    #1;
    c_next = cnt;
    if (bus.cnt_go === 1'b1)      c_next = '0;
    else if (bus.cnt_en === 1'b1) c_next = cnt + 14'd1;
    nph = m_ph;
    nt  = m_ticks;
    nr  = m_round;
    if (r != 0) begin
      nph = M_IDLE; nt = 0; nr = 0;
    end else begin
      case (m_ph)
        M_IDLE:   if (s != 0) nph = M_LOAD;
        M_LOAD:   begin nt = 0; nph = M_RUN; end
        M_RUN: begin
          nt = m_ticks + 1;
          if (cnt >= MC)             nph = M_END;
          else if (p != 0 && PEN)    nph = M_PAUSED;
        end
        M_PAUSED: if (p != 0) nph = M_RUN;
        M_END: begin
          if (m_round == RN - 1) nph = M_DONE;
          else begin nr = m_round + 1; nph = M_LOAD; end
        end
        M_DONE:   if (s != 0) begin nr = 0; nph = M_LOAD; end
        default:  nph = M_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    cnt     = c_next;
    m_ph    = nph;
    m_ticks = nt;
    m_round = nr;
    @(negedge clk);
    check_model();
    if (bus.round_done === 1'b1) rdone_seen++;
  endtask

  // Steps with idle inputs until round_done is seen; n is the number of steps taken.
  task automatic run_until_rdone(input int limit, input string name, output int n);
    n = 0;
    while (bus.round_done !== 1'b1 && n < limit) begin
      step(0, 0, 0);
      n++;
    end
    if (bus.round_done !== 1'b1) timeout_fail(name);
  endtask

  function automatic void add(input int r, s, p, go, en, rnd, busy, rd, ad);
    tbl.push_back('{r != 0, s != 0, p != 0, go != 0, en != 0, 3'(rnd), busy != 0, rd != 0, ad != 0});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;

    // First round, cycle by cycle: reset, idle, LOAD, 16 RUN cycles, ROUND_END, LOAD of round 1.
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 16; k++) add(0, 0, 0, 0, int'(k % 3 == 2), 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      step(int'(tbl[i].rst), int'(tbl[i].st), int'(tbl[i].ps));
      check($sformatf("v%0d cnt_go", i),     32'(bus.cnt_go),     32'(tbl[i].go));
      check($sformatf("v%0d cnt_en", i),     32'(bus.cnt_en),     32'(tbl[i].en));
      check($sformatf("v%0d round", i),      32'(bus.round),      32'(tbl[i].rnd));
      check($sformatf("v%0d busy", i),       32'(bus.busy),       32'(tbl[i].busy));
      check($sformatf("v%0d round_done", i), 32'(bus.round_done), 32'(tbl[i].rdone));
      check($sformatf("v%0d all_done", i),   32'(bus.all_done),   32'(tbl[i].adone));
    end

    // Round 1 to game end: LOAD seen, 16 RUN cycles, then ROUND_END.
    run_until_rdone(60, "round1 wait", n);
    check("round1 length", n, MC * TD + 2);
    step(0, 0, 0);
    check("done all_done",   32'(bus.all_done),   1);
    check("done busy",       32'(bus.busy),       0);
    check("done round",      32'(bus.round),      1);
    check("done round_done", 32'(bus.round_done), 0);
    check("round_done count", rdone_seen, 2);
    step(0, 0, 0);
    check("done holds", 32'(bus.all_done), 1);
    step(0, 1, 0);
    check("restart cnt_go", 32'(bus.cnt_go), 1);
    check("restart round",  32'(bus.round),  0);

    // Pause at prescaler phase 1, ten cycles in PAUSED, then resume.
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    n = 3;
`ifdef HAT_PAUSE_EN
    check("paused cnt_en", 32'(bus.cnt_en), 0);
`endif
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0);
`ifdef HAT_PAUSE_EN
      check("paused cnt_en", 32'(bus.cnt_en), 0);
`endif
    end
    step(0, 0, 1);
    n += 10;
`ifdef HAT_PAUSE_EN
    check("resume cnt_en", 32'(bus.cnt_en), 1);
`endif
    run_until_rdone(60, "pause round wait", m);
    check("pause round length", n + m, MC * TD + 2 + (PEN ? 10 : 0));

    // Pause arriving on the end-of-round cycle loses to end-of-round.
    step(0, 0, 0);
    n = 0;
    while (!(cnt == MC && m_ph == M_RUN) && n < 40) begin
      step(0, 0, 0);
      n++;
    end
    if (!(cnt == MC && m_ph == M_RUN)) timeout_fail("reach MAXCOUNT");
    step(0, 0, 1);
    check("pause at end round_done", 32'(bus.round_done), 1);
    step(0, 0, 0);
    check("pause at end all_done", 32'(bus.all_done), 1);

    // Reset while paused in round 1.
    step(0, 1, 0);
    run_until_rdone(60, "round0 wait", n);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    check("rst cnt_go",     32'(bus.cnt_go),     0);
    check("rst cnt_en",     32'(bus.cnt_en),     0);
    check("rst round",      32'(bus.round),      0);
    check("rst busy",       32'(bus.busy),       0);
    check("rst round_done", 32'(bus.round_done), 0);
    check("rst all_done",   32'(bus.all_done),   0);
    step(0, 0, 0);
    check("idle after rst busy", 32'(bus.busy), 0);

    // start while busy is ignored.
    step(0, 1, 0);
    step(0, 1, 0);
    check("busy start cnt_go", 32'(bus.cnt_go), 0);
    check("busy start busy",   32'(bus.busy),   1);
    step(0, 1, 0);
    check("busy start again cnt_go", 32'(bus.cnt_go), 0);

    // Counter jumps above MAXCOUNT in RUN.
    cnt = 14'd7;
    step(0, 0, 0);
    check("overrun round_done", 32'(bus.round_done), 1);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 39) == 0) cnt = 14'($urandom_range(0, 7));
      step(int'($urandom_range(0, 99) == 0), int'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
